// File: rtl/ads868x_spi_emu.sv
`default_nettype none
// ============================================================================
// Module      : ads868x_spi_emu
// Description : ADS868x SPI target emulator. Oversamples SCK/SS/SDI in the
//               aclk domain, decodes 32-bit command frames into a small
//               register file and returns conversion words sourced from an
//               AXI4-Stream sample input. Intended for loopback builds.
//
// Ports       : aclk, areset        system clock / synchronous active-high reset
//               rst_pd_n            device reset pin, low acts like areset
//               SCK, SS, SDI        SPI mode 0 inputs from the host
//               SDO_O, SDO_T        serial data out and its tristate (1 = Z)
//               s_axis_t*           conversion sample source (tready pulses)
//               range_sel           RANGE_SEL[3:0]
//               busy                conversion in progress
//               frame_done          one-cycle pulse on every SS rise
//               frame_err           pulse on short/long frame or SS fall while busy
//
// Build option: ADS868X_EMU_PARITY_EN enables DATAOUT_CTL[3] (PAR_EN), which
//               appends parity flags to the low halfword of every output word.
//
// Revision    : 1.0  initial release
// ============================================================================
module ads868x_spi_emu #(
    parameter int         DATA_WIDTH  = 16,
    parameter int         CONV_CYCLES = 100,
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] DEVICE_ID   = 4'd0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  rst_pd_n,
    input  logic                  SCK,
    input  logic                  SS,
    input  logic                  SDI,
    output logic                  SDO_O,
    output logic                  SDO_T,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [3:0]            range_sel,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(CONV_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CONV_LOAD = c_CNT_W'(CONV_CYCLES);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    // NOP (7'b0000000) needs no constant: it falls into the "no effect" path.
    localparam logic [6:0] c_OP_READ  = 7'b1100100;
    localparam logic [6:0] c_OP_WRITE = 7'b1101000;
    localparam logic [6:0] c_OP_CLEAR = 7'b1100000;
    localparam logic [6:0] c_OP_SET   = 7'b1101100;

    localparam logic [31:0] c_DEVID_REG = {12'h000, DEVICE_ID, 16'h0000};

`ifdef ADS868X_EMU_PARITY_EN
    localparam logic [31:0] c_DATAOUT_WMASK = 32'hFFFF_FFFF;
`else
    // DATAOUT_CTL[3] is held at zero; writes to it are ignored.
    localparam logic [31:0] c_DATAOUT_WMASK = 32'hFFFF_FFF7;
`endif

    // ------------------------------------------------------------------------
    // Reset and input synchronisers
    // ------------------------------------------------------------------------
    logic w_rst;
    assign w_rst = areset | ~rst_pd_n;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_sck_d;
    logic                   r_ss_d;

    // SS resets high so that a pin held low through reset release is seen as
    // a genuine falling edge and a new frame, never as a spurious rise.
    always_ff @(posedge aclk) begin
        if (w_rst) begin
            r_sck_sync <= '0;
            r_ss_sync  <= '1;
            r_sdi_sync <= '0;
            r_sck_d    <= 1'b0;
            r_ss_d     <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
            r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], SS};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
            r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
            r_ss_d     <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    logic w_sck;
    logic w_ss;
    logic w_sdi;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_ss_rise;
    logic w_ss_fall;

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_ss       = r_ss_sync[SYNC_STAGES-1];
    assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
    assign w_sck_rise =  w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck &  r_sck_d;
    assign w_ss_rise  =  w_ss  & ~r_ss_d;
    assign w_ss_fall  = ~w_ss  &  r_ss_d;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [31:0]        r_tx;
    logic [31:0]        r_rx;
    logic [5:0]         r_bitcnt;
    logic               r_sdo;
    logic               r_sdo_t;
    logic               r_frame_done;
    logic               r_frame_err;
    logic               r_pend_valid;
    logic [15:0]        r_pend_hw;
    logic [15:0]        r_result;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_conv_cnt;
    logic [31:0]        r_regs [1:5];

    // ------------------------------------------------------------------------
    // Command decode (valid only while w_ss_rise is asserted)
    // ------------------------------------------------------------------------
    logic [6:0]  w_op;
    logic [8:0]  w_addr;
    logic [15:0] w_data;
    logic [6:0]  w_idx;
    logic        w_upper;
    logic        w_decode;
    logic        w_is_rmw_op;
    logic        w_wr_en;
    logic        w_rd_en;
    logic [31:0] w_reg_rd;
    logic [15:0] w_hw_rd;
    logic [15:0] w_new_hw;
    logic [31:0] w_wr_word;

    assign w_op     = r_rx[31:25];
    assign w_addr   = r_rx[24:16];
    assign w_data   = r_rx[15:0];
    assign w_idx    = w_addr[8:2];
    assign w_upper  = w_addr[1];
    assign w_decode = w_ss_rise && (r_bitcnt == 6'd32) && !w_addr[0];

    assign w_is_rmw_op = (w_op == c_OP_WRITE) || (w_op == c_OP_CLEAR) ||
                         (w_op == c_OP_SET);
    assign w_wr_en = w_decode && w_is_rmw_op &&
                     (w_idx >= 7'd1) && (w_idx <= 7'd5);
    assign w_rd_en = w_decode && (w_op == c_OP_READ);

    // Full register selected by the frame; unmapped indexes read as zero.
    always_comb begin
        w_reg_rd = '0;
        case (w_idx)
            7'd0:    w_reg_rd = c_DEVID_REG;
            7'd1:    w_reg_rd = r_regs[1];
            7'd2:    w_reg_rd = r_regs[2];
            7'd3:    w_reg_rd = r_regs[3];
            7'd4:    w_reg_rd = r_regs[4];
            7'd5:    w_reg_rd = r_regs[5];
            default: w_reg_rd = '0;
        endcase
    end

    assign w_hw_rd = w_upper ? w_reg_rd[31:16] : w_reg_rd[15:0];

    always_comb begin
        w_new_hw = w_hw_rd;
        case (w_op)
            c_OP_WRITE: w_new_hw = w_data;
            c_OP_CLEAR: w_new_hw = w_hw_rd & ~w_data;
            c_OP_SET:   w_new_hw = w_hw_rd |  w_data;
            default:    w_new_hw = w_hw_rd;
        endcase
    end

    // Merge the modified halfword back; only DATAOUT_CTL has a masked bit.
    assign w_wr_word = (w_upper ? {w_new_hw, w_reg_rd[15:0]}
                                : {w_reg_rd[31:16], w_new_hw}) &
                       ((w_idx == 7'd4) ? c_DATAOUT_WMASK : 32'hFFFF_FFFF);

    always_ff @(posedge aclk) begin
        if (w_rst) begin
            for (int i = 1; i <= 5; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            for (int i = 1; i <= 5; i++) begin
                if (w_idx == 7'(i)) begin
                    r_regs[i] <= w_wr_word;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output word assembly
    // ------------------------------------------------------------------------
    logic [15:0] w_hw16;
    logic [15:0] w_lo16;

    // A READ_HWORD in the previous valid frame takes priority over the result.
    assign w_hw16 = r_pend_valid ? r_pend_hw : r_result;

`ifdef ADS868X_EMU_PARITY_EN
    assign w_lo16 = r_regs[4][3] ? {^w_hw16, ~^w_hw16, 14'b0} : 16'h0000;
`else
    assign w_lo16 = 16'h0000;
`endif

    // ------------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (w_rst) begin
            r_state      <= c_ST_IDLE;
            r_tx         <= '0;
            r_rx         <= '0;
            r_bitcnt     <= '0;
            r_sdo        <= 1'b0;
            r_sdo_t      <= 1'b1;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_hw    <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;

            if (w_ss_rise) begin
                // SS rise ends (or aborts) whatever is in progress.
                r_state      <= c_ST_IDLE;
                r_sdo_t      <= 1'b1;
                r_sdo        <= 1'b0;
                r_frame_done <= 1'b1;
                if (r_bitcnt != 6'd32) begin
                    r_frame_err <= 1'b1;
                end
                if (w_rd_en) begin
                    r_pend_valid <= 1'b1;
                    r_pend_hw    <= w_hw_rd;
                end
            end else if (w_ss_fall) begin
                r_state      <= c_ST_SHIFT;
                r_tx         <= {w_hw16, w_lo16};
                r_sdo        <= w_hw16[15];
                r_sdo_t      <= 1'b0;
                r_bitcnt     <= '0;
                r_pend_valid <= 1'b0;
                if (r_busy) begin
                    r_frame_err <= 1'b1;
                end
            end else if (r_state == c_ST_SHIFT) begin
                if (w_sck_rise) begin
                    r_rx <= {r_rx[30:0], w_sdi};
                    if (r_bitcnt != 6'd33) begin
                        r_bitcnt <= r_bitcnt + 6'd1;
                    end
                end
                // Zeros shift in behind the word, so SDO reads 0 past bit 32.
                if (w_sck_fall) begin
                    r_tx  <= {r_tx[30:0], 1'b0};
                    r_sdo <= r_tx[30];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Conversion timer and sample capture
    // ------------------------------------------------------------------------
    logic w_conv_last;
    assign w_conv_last = r_busy && (r_conv_cnt == c_CNT_W'(1));

    always_ff @(posedge aclk) begin
        if (w_rst) begin
            r_busy     <= 1'b0;
            r_conv_cnt <= '0;
            r_result   <= '0;
        end else if (w_ss_rise && !r_busy) begin
            r_busy     <= 1'b1;
            r_conv_cnt <= c_CONV_LOAD;
        end else if (r_busy) begin
            if (w_conv_last) begin
                r_busy     <= 1'b0;
                r_conv_cnt <= '0;
                if (s_axis_tvalid) begin
                    r_result <= 16'(s_axis_tdata);
                end
            end else begin
                r_conv_cnt <= r_conv_cnt - c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign SDO_O         = r_sdo;
    assign SDO_T         = r_sdo_t;
    assign s_axis_tready = ~w_rst & w_conv_last & s_axis_tvalid;
    assign range_sel     = r_regs[5][3:0];
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ads868x_spi_emu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ads868x_spi_emu
// Description : Self-checking bench for ads868x_spi_emu. Drives SPI frames as
//               a host would, and predicts every returned word, register and
//               pulse count from a behavioural model of the device rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ads868x_spi_emu;

    localparam int         c_DW    = 16;
    localparam int         c_CONV  = 20;
    localparam int         c_SYNC  = 2;
    localparam logic [3:0] c_DEVID = 4'hA;
    localparam int         c_HALF  = 8;   // aclk cycles per SCK half period
    localparam int         c_LONG  = 40;  // gap that outlasts any conversion

`ifdef ADS868X_EMU_PARITY_EN
    localparam bit c_PAR_BUILD = 1'b1;
`else
    localparam bit c_PAR_BUILD = 1'b0;
`endif

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic            rst_pd_n = 1'b1;
    logic            SCK = 1'b0;
    logic            SS = 1'b1;
    logic            SDI = 1'b0;
    logic            SDO_O;
    logic            SDO_T;
    logic [c_DW-1:0] s_axis_tdata = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [3:0]      range_sel;
    logic            busy;
    logic            frame_done;
    logic            frame_err;

    always #5 aclk = ~aclk;

    ads868x_spi_emu #(
        .DATA_WIDTH (c_DW),
        .CONV_CYCLES(c_CONV),
        .SYNC_STAGES(c_SYNC),
        .DEVICE_ID  (c_DEVID)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .rst_pd_n     (rst_pd_n),
        .SCK          (SCK),
        .SS           (SS),
        .SDI          (SDI),
        .SDO_O        (SDO_O),
        .SDO_T        (SDO_T),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .range_sel    (range_sel),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_err    (frame_err)
    );

    // Pulse counters
    int n_done   = 0;
    int n_err    = 0;
    int n_tready = 0;

    always @(posedge aclk) begin
        if (frame_done)    n_done++;
        if (frame_err)     n_err++;
        if (s_axis_tready) n_tready++;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural device model
    // ------------------------------------------------------------------------
    logic [31:0] m_reg [0:5];
    logic [15:0] m_result;
    logic        m_pend_valid;
    logic [15:0] m_pend_hw;
    logic        m_conv_pend;   // a conversion was started and not yet folded in
    logic        m_conv_val;
    logic [15:0] m_conv_data;
    int          exp_tready;

    task automatic model_reset();
        m_reg[0]     = {12'h000, c_DEVID, 16'h0000};
        for (int i = 1; i <= 5; i++) m_reg[i] = '0;
        m_result     = '0;
        m_pend_valid = 1'b0;
        m_pend_hw    = '0;
        m_conv_pend  = 1'b0;
        m_conv_val   = 1'b0;
        m_conv_data  = '0;
    endtask

    task automatic model_commit();
        if (m_conv_pend && m_conv_val) begin
            m_result = m_conv_data;
            exp_tready++;
        end
        m_conv_pend = 1'b0;
    endtask

    function automatic logic [15:0] model_hw(input int idx, input bit up);
        if (idx > 5) return 16'h0000;
        return up ? m_reg[idx][31:16] : m_reg[idx][15:0];
    endfunction

    task automatic model_decode(input logic [31:0] cmd);
        logic [6:0]  op;
        logic [8:0]  addr;
        logic [15:0] d;
        logic [15:0] hw;
        int          idx;
        bit          up;
        op   = cmd[31:25];
        addr = cmd[24:16];
        d    = cmd[15:0];
        idx  = int'(addr) / 4;
        up   = addr[1];
        if (addr[0]) return;
        hw = model_hw(idx, up);
        if (op == 7'b1100100) begin
            m_pend_valid = 1'b1;
            m_pend_hw    = hw;
            return;
        end
        if (idx < 1 || idx > 5) return;
        if      (op == 7'b1101000) hw = d;
        else if (op == 7'b1100000) hw = hw & ~d;
        else if (op == 7'b1101100) hw = hw | d;
        else return;
        if (up) m_reg[idx][31:16] = hw;
        else    m_reg[idx][15:0]  = hw;
        if (idx == 4 && !c_PAR_BUILD) m_reg[4][3] = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // One host frame: nbits clocked, then SS rise and gap cycles of idle.
    // ------------------------------------------------------------------------
    task automatic spi_frame(input logic [31:0] mosi, input int nbits,
                             input int gap, input string tag);
        logic [15:0] hw;
        logic [15:0] lo;
        logic [31:0] exp_word;
        logic [31:0] miso;
        int          done0;
        int          err0;
        int          exp_err;

        hw = m_pend_valid ? m_pend_hw : m_result;
        m_pend_valid = 1'b0;
        lo = m_reg[4][3] ? {^hw, ~^hw, 14'b0} : 16'h0000;
        exp_word = {hw, lo};
        exp_err  = (m_conv_pend ? 1 : 0) + ((nbits != 32) ? 1 : 0);
        done0 = n_done;
        err0  = n_err;
        miso  = '0;

        @(negedge aclk);
        SS  = 1'b0;
        SDI = mosi[31];
        repeat (c_HALF) @(negedge aclk);
        for (int b = 0; b < nbits; b++) begin
            miso = {miso[30:0], SDO_O};
            if (b == nbits / 2) check({tag, "_sdo_t_active"}, 32'(SDO_T), 32'd0);
            SCK = 1'b1;
            repeat (c_HALF) @(negedge aclk);
            SCK = 1'b0;
            if (b + 1 < nbits) SDI = mosi[30 - b];
            repeat (c_HALF) @(negedge aclk);
        end
        SS  = 1'b1;
        SDI = 1'b0;

        model_commit();          // anything earlier has finished by now
        m_conv_pend = 1'b1;
        m_conv_val  = s_axis_tvalid;
        m_conv_data = 16'(s_axis_tdata);
        if (nbits == 32) model_decode(mosi);

        repeat (6) @(negedge aclk);
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_sdo_t_idle"}, 32'(SDO_T), 32'd1);
        if (gap > 6) repeat (gap - 6) @(negedge aclk);
        if (gap >= c_LONG) begin
            model_commit();
            check({tag, "_busy_end"}, 32'(busy), 32'd0);
            check({tag, "_tready_cnt"}, 32'(n_tready), 32'(exp_tready));
        end
        check({tag, "_miso"}, miso, exp_word >> (32 - nbits));
        check({tag, "_done_cnt"}, 32'(n_done - done0), 32'd1);
        check({tag, "_err_cnt"}, 32'(n_err - err0), 32'(exp_err));
    endtask

    // ------------------------------------------------------------------------
    // Directed and randomized sequence
    // ------------------------------------------------------------------------
    logic [6:0] ops [0:5];

    initial begin
        exp_tready = 0;
        model_reset();
        ops[0] = 7'b0000000; ops[1] = 7'b1100100; ops[2] = 7'b1101000;
        ops[3] = 7'b1100000; ops[4] = 7'b1101100; ops[5] = 7'b1010101;

        repeat (5) @(negedge aclk);
        areset = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_sdo_t", 32'(SDO_T), 32'd1);
        check("rst_sdo_o", 32'(SDO_O), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_range", 32'(range_sel), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);

        // Result path: first word is the reset result, next the new sample.
        s_axis_tdata  = 16'h1234;
        s_axis_tvalid = 1'b1;
        spi_frame(32'h0000_0000, 32, c_LONG, "t1a");
        spi_frame(32'h0000_0000, 32, c_LONG, "t1b");

        // Write, read back through the pending halfword.
        spi_frame(32'hD014_0005, 32, c_LONG, "t2w");
        check("t2_range", 32'(range_sel), 32'd5);
        spi_frame(32'hC814_0000, 32, c_LONG, "t2r");
        spi_frame(32'h0000_0000, 32, c_LONG, "t2n");

        // Set / clear and read-only DEVICE_ID.
        spi_frame(32'hD014_0000, 32, c_LONG, "t3z");
        spi_frame(32'hD814_0003, 32, c_LONG, "t3s");
        spi_frame(32'hC014_0001, 32, c_LONG, "t3c");
        check("t3_range", 32'(range_sel), 32'd2);
        spi_frame(32'hD000_FFFF, 32, c_LONG, "t3id_w");
        spi_frame(32'hC802_0000, 32, c_LONG, "t3id_r");
        spi_frame(32'h0000_0000, 32, c_LONG, "t3id_n");

        // Short frame, then a frame starting while busy.
        s_axis_tdata = 16'hBEEF;
        spi_frame(32'hD014_000F, 20, c_LONG, "t4short");
        check("t4_range", 32'(range_sel), 32'd2);
        s_axis_tdata = 16'h5A5A;
        spi_frame(32'h0000_0000, 32, 6, "t4a");
        spi_frame(32'h0000_0000, 32, c_LONG, "t4b");

        // No sample available: result repeats, no tready.
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'h7777;
        spi_frame(32'h0000_0000, 32, c_LONG, "t5a");
        spi_frame(32'h0000_0000, 32, c_LONG, "t5b");

        // Output word low half with PAR_EN requested.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'h0007;
        spi_frame(32'hD010_0008, 32, c_LONG, "t6w");
        spi_frame(32'h0000_0000, 32, c_LONG, "t6n");

        // Randomized commands against the model.
        for (int n = 0; n < 24; n++) begin
            logic [6:0]  op;
            logic [6:0]  idx;
            logic [8:0]  addr;
            logic [31:0] cmd;
            op   = ops[$urandom_range(0, 5)];
            idx  = 7'($urandom_range(0, 7));
            addr = {idx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0)};
            cmd  = {op, addr, 16'($urandom)};
            s_axis_tdata  = 16'($urandom);
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            spi_frame(cmd, 32, c_LONG, "rnd");
            check("rnd_range", 32'(range_sel), 32'(m_reg[5][3:0]));
        end

        // Device reset pin pulled low in the middle of a frame.
        spi_frame(32'hD014_0009, 32, c_LONG, "t5pw");
        @(negedge aclk);
        SS = 1'b0;
        SDI = 1'b1;
        repeat (c_HALF) @(negedge aclk);
        for (int b = 0; b < 5; b++) begin
            SCK = 1'b1;
            repeat (c_HALF) @(negedge aclk);
            SCK = 1'b0;
            repeat (c_HALF) @(negedge aclk);
        end
        check("t5p_sdo_t_pre", 32'(SDO_T), 32'd0);
        rst_pd_n = 1'b0;
        repeat (4) @(negedge aclk);
        check("t5p_sdo_t", 32'(SDO_T), 32'd1);
        check("t5p_sdo_o", 32'(SDO_O), 32'd0);
        check("t5p_busy", 32'(busy), 32'd0);
        check("t5p_range", 32'(range_sel), 32'd0);
        SS  = 1'b1;
        SDI = 1'b0;
        repeat (6) @(negedge aclk);
        rst_pd_n = 1'b1;
        model_reset();
        repeat (10) @(negedge aclk);
        spi_frame(32'hC814_0000, 32, c_LONG, "t5pr");
        spi_frame(32'h0000_0000, 32, c_LONG, "t5pn");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
